// File: rtl/inst_loader_pkg.sv
// Shared types and sizing for the instruction loader: loader FSM encoding and
// instruction-memory geometry.
package inst_loader_pkg;

   localparam int LDR_CPU_WIDTH  = 32;
   localparam int LDR_ADDR_WIDTH = 8;
   localparam int LDR_DEPTH      = 256;

   typedef enum logic [2:0] {
      LDR_IDLE  = 3'd0,
      LDR_LOAD  = 3'd1,
      LDR_CHECK = 3'd2,
      LDR_DONE  = 3'd3,
      LDR_ERR   = 3'd4
   } ldr_state_e;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Assembles four little-endian bytes into one 32-bit word; word_valid_o fires
// combinationally with the fourth byte so the caller can register the write.
module byte_packer
   import inst_loader_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     byte_valid_i,
   input  logic [7:0]               byte_data_i,
   output logic                     word_valid_o,
   output logic [LDR_CPU_WIDTH-1:0] word_o
);

   logic [1:0]  cnt_q,  cnt_d;
   logic [23:0] word_q, word_d;

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clear_i) begin
         cnt_d  = '0;
         word_d = '0;
      end else if (byte_valid_i) begin
         cnt_d = cnt_q + 2'd1;
         case (cnt_q)
            2'd0:    word_d[7:0]   = byte_data_i;
            2'd1:    word_d[15:8]  = byte_data_i;
            2'd2:    word_d[23:16] = byte_data_i;
            default: word_d        = word_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
   assign word_o       = {byte_data_i, word_q};

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: streams a byte-packed program into inst_mem at word
// addresses 0..N-1, verifies an XOR checksum, then enables the core.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = LDR_ADDR_WIDTH,
   parameter int DEPTH      = LDR_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDR_WIDTH:0]      load_len,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     mem_wen,
   output logic [ADDR_WIDTH-1:0]    mem_waddr,
   output logic [LDR_CPU_WIDTH-1:0] mem_wdata,
   output logic                     core_ena,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   ldr_state_e                 state_q, state_d;
   logic [ADDR_WIDTH:0]        len_q, len_d;
   logic [ADDR_WIDTH:0]        word_idx_q, word_idx_d, word_idx_inc;
   logic [7:0]                 chk_q, chk_d;
   logic                       mem_wen_q;
   logic [ADDR_WIDTH-1:0]      mem_waddr_q;
   logic [LDR_CPU_WIDTH-1:0]   mem_wdata_q;

   logic                       accept;
   logic                       pack_clear;
   logic                       word_valid;
   logic [LDR_CPU_WIDTH-1:0]   word;

   assign in_ready     = (state_q == LDR_LOAD) || (state_q == LDR_CHECK);
   assign accept       = in_valid && in_ready;
   assign word_idx_inc = word_idx_q + 1'b1;

   byte_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (pack_clear),
      .byte_valid_i (accept && (state_q == LDR_LOAD)),
      .byte_data_i  (in_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      chk_d      = chk_q;
      pack_clear = 1'b0;
      case (state_q)
         LDR_IDLE, LDR_DONE, LDR_ERR: begin
            if (start) begin
               if ((load_len == '0) || (load_len > DEPTH_L)) begin
                  state_d = LDR_ERR;
               end else begin
                  state_d    = LDR_LOAD;
                  len_d      = load_len;
                  word_idx_d = '0;
                  chk_d      = '0;
                  pack_clear = 1'b1;
               end
            end
         end
         LDR_LOAD: begin
            if (accept) chk_d = chk_q ^ in_data;
            if (word_valid) begin
               word_idx_d = word_idx_inc;
               if (word_idx_inc == len_q) state_d = LDR_CHECK;
            end
         end
         LDR_CHECK: begin
            // The checksum byte is compared only, never packed or written.
            if (accept) state_d = (in_data == chk_q) ? LDR_DONE : LDR_ERR;
         end
         default: state_d = LDR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LDR_IDLE;
         len_q       <= '0;
         word_idx_q  <= '0;
         chk_q       <= '0;
         mem_wen_q   <= 1'b0;
         mem_waddr_q <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         chk_q      <= chk_d;
         mem_wen_q  <= word_valid;
         // Address and data hold their last written values between pulses.
         if (word_valid) begin
            mem_waddr_q <= word_idx_q[ADDR_WIDTH-1:0];
            mem_wdata_q <= word;
         end
      end
   end

   assign mem_wen   = mem_wen_q;
   assign mem_waddr = mem_waddr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = in_ready;
   assign done      = (state_q == LDR_DONE);
   assign err       = (state_q == LDR_ERR);
   assign core_ena  = (state_q == LDR_DONE);

endmodule
